pipe_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It detects load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses in MEM. It drives hold and bubble controls to the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It also runs a memory-wait state machine with timeout, and keeps saturating performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline: load-use bubbles, EX-resolved
// branch flushes, and a frozen-pipeline wait on slow data memory with timeout.
module pipe_hazard_ctrl #(
    parameter logic [1:0]  WD_DRAM     = 2'b01,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_cpu,
    input  logic             rst_cpu,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             re1_id,
    input  logic             re2_id,
    input  logic [4:0]       rd_ex,
    input  logic             rd_we_ex,
    input  logic [1:0]       wd_sel_ex,
    input  logic             flag_ex,
    input  logic             dram_req_mem,
    input  logic             dram_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_busy;
    logic freeze;
    logic normal;

    assign load_use = rd_we_ex && (wd_sel_ex == WD_DRAM) && (rd_ex != 5'd0) &&
                      ((re1_id && (rs1_id == rd_ex)) || (re2_id && (rs2_id == rd_ex)));
    assign mem_busy = dram_req_mem && !dram_ready;

    // Next-state logic and stall/flush decode from state plus live hazards
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        mem_err_d    = mem_err_q;
        freeze       = 1'b0;
        normal       = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_busy) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                    wait_d  = 8'd1;
                end else begin
                    normal = 1'b1;
                end
            end
            StMemWait: begin
                if (dram_ready) begin
                    // Release cycle: hazards held stable during the freeze act now
                    normal  = 1'b1;
                    state_d = StRun;
                    wait_d  = 8'd0;
                end else if (wait_q == TimeoutVal) begin
                    freeze    = 1'b1;
                    state_d   = StErr;
                    mem_err_d = 1'b1;
                end else begin
                    freeze = 1'b1;
                    wait_d = wait_q + 8'd1;
                end
            end
            StErr: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (!rst_cpu) begin
            if (freeze) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (normal) begin
                if (flag_ex) begin
                    // Wrong-path ID instruction: flush wins over load-use
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_if_id && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            state_q     <= StRun;
            wait_q      <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    localparam logic [6:0] CtlNone   = 7'b0000000;
    localparam logic [6:0] CtlFreeze = 7'b1111001;
    localparam logic [6:0] CtlBranch = 7'b0000110;
    localparam logic [6:0] CtlLoadUs = 7'b1100010;

    logic          clk_cpu;
    logic          rst_cpu;
    logic [4:0]    rs1_id, rs2_id, rd_ex;
    logic          re1_id, re2_id, rd_we_ex, flag_ex, dram_req_mem, dram_ready;
    logic [1:0]    wd_sel_ex;
    logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic          flush_if_id, flush_id_ex, flush_mem_wb, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctl;

    int checks = 0;
    int errors = 0;

    // Model state: consecutive unserved-access cycles, error trap, counters
    int m_fc    = 0;
    bit m_err   = 0;
    bit m_merr  = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_hazard_ctrl #(
        .WD_DRAM     (2'b01),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk_cpu      (clk_cpu),
        .rst_cpu      (rst_cpu),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .re1_id       (re1_id),
        .re2_id       (re2_id),
        .rd_ex        (rd_ex),
        .rd_we_ex     (rd_we_ex),
        .wd_sel_ex    (wd_sel_ex),
        .flag_ex      (flag_ex),
        .dram_req_mem (dram_req_mem),
        .dram_ready   (dram_ready),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_mem_wb (flush_mem_wb),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                  flush_if_id, flush_id_ex, flush_mem_wb};

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    // Does the ID instruction read the register the EX load is about to produce?
    function automatic bit model_lu();
        bit hit1 = re1_id && (rs1_id == rd_ex);
        bit hit2 = re2_id && (rs2_id == rd_ex);
        return rd_we_ex && (wd_sel_ex == 2'b01) && (rd_ex != 0) && (hit1 || hit2);
    endfunction

    function automatic bit model_frozen();
        if (m_err) return 1'b1;
        if (m_fc > 0) return !dram_ready;
        return dram_req_mem && !dram_ready;
    endfunction

    function automatic logic [6:0] model_ctl();
        if (rst_cpu) return CtlNone;
        if (model_frozen()) return CtlFreeze;
        if (flag_ex) return CtlBranch;
        if (model_lu()) return CtlLoadUs;
        return CtlNone;
    endfunction

    // Advance the model on every clock edge using the inputs held across it
    always @(posedge clk_cpu) begin
        logic [6:0] c;
        c = model_ctl();
        if (rst_cpu) begin
            m_fc = 0; m_err = 0; m_merr = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (c[6] && m_stall < CMAX) m_stall++;
            if (c[2] && m_flush < CMAX) m_flush++;
            if (!m_err) begin
                if (m_fc > 0) begin
                    if (dram_ready) m_fc = 0;
                    else begin
                        m_fc++;
                        // The access has now gone unserved for more than TO waits
                        if (m_fc > TO) m_err = 1;
                    end
                end else if (dram_req_mem && !dram_ready) begin
                    m_fc = 1;
                end
            end
            m_merr = m_err;
        end
    end

    task automatic set_idle();
        rst_cpu = 0; rs1_id = 0; rs2_id = 0; re1_id = 0; re2_id = 0;
        rd_ex = 0; rd_we_ex = 0; wd_sel_ex = 0; flag_ex = 0;
        dram_req_mem = 0; dram_ready = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        set_idle();
        rd_ex = rd; rd_we_ex = 1; wd_sel_ex = 2'b01; re1_id = 1; rs1_id = 5'd5;
    endtask

    task automatic do_reset();
        @(negedge clk_cpu); set_idle(); rst_cpu = 1;
        @(negedge clk_cpu); rst_cpu = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_cpu);
            set_load_use(5'd5); dram_req_mem = 1; flag_ex = 1; rst_cpu = 1;
            #1;
            checks++;
            if (ctl !== CtlNone) begin
                errors++; $display("FAIL reset_ctl got %b want %b", ctl, CtlNone);
            end
        end
        @(negedge clk_cpu); set_idle(); #1;
        checks++;
        if (mem_err !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got err=%b sc=%0d fc=%0d want 0 0 0",
                     mem_err, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk_cpu); set_load_use(5'd5); #1;
        checks++;
        if (ctl !== CtlLoadUs) begin
            errors++; $display("FAIL load_use_ctl got %b want %b", ctl, CtlLoadUs);
        end
        @(negedge clk_cpu); set_idle(); #1;
        checks++;
        if (ctl !== CtlNone || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_after got ctl=%b sc=%0d want %b 1", ctl, stall_cnt, CtlNone);
        end
        @(negedge clk_cpu); set_load_use(5'd0); rs1_id = 5'd0; #1;
        checks++;
        if (ctl !== CtlNone) begin
            errors++; $display("FAIL load_use_x0 got %b want %b", ctl, CtlNone);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk_cpu); set_load_use(5'd5); flag_ex = 1; #1;
        checks++;
        if (ctl !== CtlBranch) begin
            errors++; $display("FAIL branch_ctl got %b want %b", ctl, CtlBranch);
        end
        @(negedge clk_cpu); set_idle(); #1;
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL branch_cnt got fc=%0d sc=%0d want 1 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_cpu); set_idle(); dram_req_mem = 1; #1;
            checks++;
            if (ctl !== CtlFreeze) begin
                errors++; $display("FAIL mem_wait_c%0d got %b want %b", i, ctl, CtlFreeze);
            end
        end
        @(negedge clk_cpu); set_idle(); dram_req_mem = 1; dram_ready = 1; #1;
        checks++;
        if (ctl !== CtlNone) begin
            errors++; $display("FAIL mem_release got %b want %b", ctl, CtlNone);
        end
        // A plain load-use with no access pending proves the FSM is back in RUN
        @(negedge clk_cpu); set_load_use(5'd5); #1;
        checks++;
        if (ctl !== CtlLoadUs || stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL mem_back_run got ctl=%b sc=%0d want %b 3", ctl, stall_cnt, CtlLoadUs);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_cpu); set_idle(); dram_req_mem = 1; #1;
            checks++;
            if (ctl !== CtlFreeze || mem_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_c%0d got ctl=%b err=%b want %b 0", i, ctl, mem_err, CtlFreeze);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_cpu); set_idle(); dram_ready = 1; flag_ex = 1; #1;
            checks++;
            if (ctl !== CtlFreeze || mem_err !== 1'b1) begin
                errors++;
                $display("FAIL err_hold%0d got ctl=%b err=%b want %b 1", i, ctl, mem_err, CtlFreeze);
            end
        end
        @(negedge clk_cpu); set_idle(); rst_cpu = 1; #1;
        checks++;
        if (stall_cnt !== 4'd8 || ctl !== CtlNone) begin
            errors++;
            $display("FAIL err_rst_in got sc=%0d ctl=%b want 8 %b", stall_cnt, ctl, CtlNone);
        end
        @(negedge clk_cpu); set_idle(); #1;
        checks++;
        if (mem_err !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || ctl !== CtlNone) begin
            errors++;
            $display("FAIL err_cleared got err=%b sc=%0d fc=%0d ctl=%b want 0 0 0 %b",
                     mem_err, stall_cnt, flush_cnt, ctl, CtlNone);
        end
    endtask

    task automatic test_release_branch();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_cpu); set_idle(); dram_req_mem = 1; flag_ex = 1; #1;
            checks++;
            if (ctl !== CtlFreeze) begin
                errors++; $display("FAIL rel_br_frozen%0d got %b want %b", i, ctl, CtlFreeze);
            end
        end
        @(negedge clk_cpu); set_idle(); dram_req_mem = 1; dram_ready = 1; flag_ex = 1; #1;
        checks++;
        if (ctl !== CtlBranch) begin
            errors++; $display("FAIL rel_br_release got %b want %b", ctl, CtlBranch);
        end
        @(negedge clk_cpu); set_idle(); #1;
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL rel_br_cnt got fc=%0d sc=%0d want 1 2", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_cpu); set_load_use(5'd5); #1;
        end
        @(negedge clk_cpu); set_idle(); #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL saturation got sc=%0d want 15", stall_cnt);
        end
    endtask

    task automatic test_random();
        int nfail = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_cpu);
            set_idle();
            rst_cpu      = ($urandom_range(0, 99) < 3);
            rs1_id       = 5'($urandom_range(0, 3));
            rs2_id       = 5'($urandom_range(0, 3));
            rd_ex        = 5'($urandom_range(0, 3));
            re1_id       = 1'($urandom_range(0, 1));
            re2_id       = 1'($urandom_range(0, 1));
            rd_we_ex     = 1'($urandom_range(0, 1));
            wd_sel_ex    = 2'($urandom_range(0, 3));
            flag_ex      = ($urandom_range(0, 99) < 20);
            dram_req_mem = ($urandom_range(0, 99) < 30);
            dram_ready   = ($urandom_range(0, 99) < 45);
            #1;
            checks++;
            if (ctl !== model_ctl() || mem_err !== m_merr ||
                stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
                errors++;
                nfail++;
                if (nfail <= 20) begin
                    $display("FAIL random_c%0d got ctl=%b err=%b sc=%0d fc=%0d want %b %b %0d %0d",
                             i, ctl, mem_err, stall_cnt, flush_cnt,
                             model_ctl(), m_merr, m_stall, m_flush);
                end
            end
        end
    endtask

    initial begin
        set_idle();
        rst_cpu = 1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_release_branch();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
